conv_job_scheduler: RTL

Controller in front of the `convolution` core: it shares one core between `NREQ` requesters, each presenting its own 3×3 kernel and normalisation shift. It round-robin arbitrates pending jobs, drives the core's kernel/shift configuration and single-cycle start pulse, and waits for `done` under a watchdog. It then reports completion or timeout back to the granted requester.

---
 rtl/conv_ctrl_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 30 +++
 rtl/conv_job_scheduler.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/conv_ctrl_pkg.sv
// Shared types and constants for the convolution job scheduler.
// Kernels are packed row-major, tap i at [i*KW +: KW].
package conv_ctrl_pkg;

  localparam int NTAPS   = 9;
  localparam int DEF_KW  = 8;
  localparam int DEF_SHW = 4;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_LOAD   = 3'd1;
  localparam state_t ST_START  = 3'd2;
  localparam state_t ST_RUN    = 3'd3;
  localparam state_t ST_FINISH = 3'd4;

  // Bit offset of a tap within a packed kernel word.
  function automatic int tap_lsb(input int tap, input int kw);
    return tap * kw;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after rr_ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_ptr,
  output logic [NREQ-1:0] win_oh,
  output logic [IW-1:0]   win_idx,
  output logic            any
);

  always_comb begin : p_pick
    int cand;
    any     = 1'b0;
    win_idx = '0;
    win_oh  = '0;
    cand    = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(rr_ptr) + k) % NREQ;
      if (!any && req[cand]) begin
        any          = 1'b1;
        win_idx      = IW'(cand);
        win_oh[cand] = 1'b1;
      end else begin
      end
    end
  end

endmodule

// File: rtl/conv_job_scheduler.sv
// Shares one convolution core between NREQ requesters: round-robin grant,
// latched kernel/shift, start pulse, done-edge wait under a watchdog.
module conv_job_scheduler
  import conv_ctrl_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 20000,
  parameter int KW      = DEF_KW,
  parameter int SHW     = DEF_SHW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*NTAPS*KW-1:0] kernel_in,
  input  logic [NREQ*SHW-1:0]      shift_in,
  output logic [NREQ-1:0]          grant,
  output logic                     busy,
  output logic                     conv_start,
  output logic [NTAPS*KW-1:0]      conv_kernel,
  output logic [SHW-1:0]           conv_shift,
  input  logic                     conv_done,
  output logic [NREQ-1:0]          ack,
  output logic [NREQ-1:0]          err
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  // Last RUN cycle is the one whose increment would reach TIMEOUT-1.
  localparam logic [CW-1:0] EXPIRE = CW'(TIMEOUT - 2);

  state_t                state_q, state_d;
  logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0]       grant_q, grant_d;
  logic                  busy_q, busy_d;
  logic                  start_q, start_d;
  logic [NTAPS*KW-1:0]   kernel_q, kernel_d;
  logic [SHW-1:0]        shift_q, shift_d;
  logic [NREQ-1:0]       ack_q, ack_d;
  logic [NREQ-1:0]       err_q, err_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  done_prev_q, done_prev_d;

  logic [NREQ-1:0]       arb_oh;
  logic [IW-1:0]         arb_idx;
  logic                  arb_any;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req     (req),
    .rr_ptr  (rr_ptr_q),
    .win_oh  (arb_oh),
    .win_idx (arb_idx),
    .any     (arb_any)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    busy_d      = busy_q;
    start_d     = 1'b0;
    kernel_d    = kernel_q;
    shift_d     = shift_q;
    ack_d       = '0;
    err_d       = '0;
    cnt_d       = cnt_q;
    done_prev_d = done_prev_q;
    case (state_q)
      ST_IDLE: begin
        grant_d = '0;
        busy_d  = 1'b0;
        // Skip arbitration while an err pulse is out: its owner cannot have dropped req yet.
        if (arb_any && (err_q == '0)) begin
          state_d  = ST_LOAD;
          grant_d  = arb_oh;
          busy_d   = 1'b1;
          kernel_d = kernel_in[tap_lsb(NTAPS * int'(arb_idx), KW) +: NTAPS*KW];
          shift_d  = shift_in[int'(arb_idx) * SHW +: SHW];
          rr_ptr_d = (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + IW'(1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        start_d = 1'b1;
        state_d = ST_START;
      end
      ST_START: begin
        cnt_d       = '0;
        done_prev_d = conv_done;
        state_d     = ST_RUN;
      end
      ST_RUN: begin
        done_prev_d = conv_done;
        if (conv_done && !done_prev_q) begin
          ack_d   = grant_q;
          state_d = ST_FINISH;
        end else if (cnt_q == EXPIRE) begin
          err_d   = grant_q;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_FINISH: begin
        grant_d = '0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        grant_d = '0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      busy_q      <= 1'b0;
      start_q     <= 1'b0;
      kernel_q    <= '0;
      shift_q     <= '0;
      ack_q       <= '0;
      err_q       <= '0;
      cnt_q       <= '0;
      done_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
      start_q     <= start_d;
      kernel_q    <= kernel_d;
      shift_q     <= shift_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      done_prev_q <= done_prev_d;
    end
  end

  assign grant       = grant_q;
  assign busy        = busy_q;
  assign conv_start  = start_q;
  assign conv_kernel = kernel_q;
  assign conv_shift  = shift_q;
  assign ack         = ack_q;
  assign err         = err_q;

endmodule
